// File: rtl/coin_collector.sv
// coin_collector: owns one coin's lifecycle. It removes the tile on a touch,
// scores it in saturating BCD, plays the pop animation, and restores the tile
// on respawn.
module coin_collector #(
   parameter logic [2:0]  TKN        = 3'd4,
   parameter logic [2:0]  SKY        = 3'd1,
   parameter int unsigned COIN_VALUE = 1,
   parameter int unsigned POP_FRAMES = 16,
   parameter int unsigned POP_STEP   = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               touch,
   input  logic signed [31:0] x,
   input  logic signed [31:0] y,
   input  logic               frame_tick,
   input  logic               respawn,
   output logic               map_wr_req,
   output logic signed [31:0] map_wr_x,
   output logic signed [31:0] map_wr_y,
   output logic [2:0]         map_wr_tile,
   input  logic               map_wr_ack,
   output logic               coin_visible,
   output logic               pop_active,
   output logic signed [31:0] pop_offset,
   output logic [15:0]        score,
   output logic               score_inc,
   output logic [7:0]         coin_count
);

   typedef enum logic [2:0] {
      PRESENT,
      CLEAR_REQ,
      POP,
      COLLECTED,
      RESTORE_REQ
   } state_t;

   localparam logic [3:0]         CV       = 4'(COIN_VALUE);
   localparam logic [15:0]        POP_LAST = 16'(POP_FRAMES - 1);
   localparam logic signed [31:0] STEP_S   = signed'(32'(POP_STEP));

   state_t      state, state_nx;
   logic        touch_d;
   logic [15:0] pop_cnt;
   logic        collect;
   logic        restore;
   logic        pop_tick;

   // Digit-serial BCD add with ripple carry; a carry out of the thousands
   // digit means the result passed 9999, so the sum is clamped.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                                input logic [3:0]  v);
      logic [15:0] r;
      logic [4:0]  d;
      logic        c;
      r = '0;
      c = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         d = {1'b0, a[4*i +: 4]} + {1'b0, ((i == 0) ? v : 4'd0)} + {4'd0, c};
         if (d > 5'd9) begin
            r[4*i +: 4] = 4'(d - 5'd10);
            c           = 1'b1;
         end else begin
            r[4*i +: 4] = d[3:0];
            c           = 1'b0;
         end
      end
      if (c) r = 16'h9999;
      return r;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= PRESENT;
      else          state <= state_nx;
   end

   // Next-state decode and state-derived indicator outputs
   always_comb begin
      state_nx     = state;
      coin_visible = 1'b0;
      map_wr_req   = 1'b0;
      pop_active   = 1'b0;
      collect      = 1'b0;
      restore      = 1'b0;
      pop_tick     = 1'b0;
      case (state)
         PRESENT: begin
            coin_visible = 1'b1;
            if (touch && !touch_d) begin
               collect  = 1'b1;
               state_nx = CLEAR_REQ;
            end
         end
         CLEAR_REQ: begin
            map_wr_req = 1'b1;
            if (map_wr_ack) state_nx = POP;
         end
         POP: begin
            pop_active = 1'b1;
            pop_tick   = frame_tick;
            if (frame_tick && pop_cnt == POP_LAST) state_nx = COLLECTED;
         end
         COLLECTED: begin
            if (respawn) begin
               restore  = 1'b1;
               state_nx = RESTORE_REQ;
            end
         end
         RESTORE_REQ: begin
            map_wr_req = 1'b1;
            if (map_wr_ack) state_nx = PRESENT;
         end
         default: state_nx = PRESENT;
      endcase
   end

   // Datapath: edge detect, write address/tile capture, score, animation
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         touch_d     <= 1'b0;
         map_wr_x    <= '0;
         map_wr_y    <= '0;
         map_wr_tile <= SKY;
         pop_cnt     <= '0;
         pop_offset  <= '0;
         score       <= '0;
         score_inc   <= 1'b0;
         coin_count  <= '0;
      end else begin
         touch_d   <= touch;
         score_inc <= collect;
         if (collect) begin
            map_wr_x    <= x;
            map_wr_y    <= y;
            map_wr_tile <= SKY;
            score       <= bcd_add_sat(score, CV);
            if (coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
         end
         if (restore) begin
            map_wr_x    <= x;
            map_wr_y    <= y;
            map_wr_tile <= TKN;
         end
         if (state == CLEAR_REQ && map_wr_ack) begin
            pop_cnt    <= '0;
            pop_offset <= '0;
         end
         if (pop_tick) begin
            if (pop_cnt == POP_LAST) begin
               pop_offset <= '0;
            end else begin
               pop_cnt    <= pop_cnt + 16'd1;
               pop_offset <= pop_offset + STEP_S;
            end
         end
      end
   end

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: directed vectors for coin_collector. A value-1 instance
// and a value-9 instance run from the same stimulus.
module tb_coin_collector;

   logic        clk = 1'b0;
   logic        reset_n, touch, frame_tick, respawn, map_wr_ack;
   int          x, y;

   logic        req, vis, pact, sinc;
   int          wx, wy, off;
   logic [2:0]  tile;
   logic [15:0] score;
   logic [7:0]  cnt;

   logic        req9, vis9, pact9, sinc9;
   int          wx9, wy9, off9;
   logic [2:0]  tile9;
   logic [15:0] score9;
   logic [7:0]  cnt9;

   int checks = 0;
   int errors = 0;

   coin_collector #(.COIN_VALUE(1)) dut (
      .clk(clk), .reset_n(reset_n), .touch(touch), .x(x), .y(y),
      .frame_tick(frame_tick), .respawn(respawn),
      .map_wr_req(req), .map_wr_x(wx), .map_wr_y(wy), .map_wr_tile(tile),
      .map_wr_ack(map_wr_ack), .coin_visible(vis), .pop_active(pact),
      .pop_offset(off), .score(score), .score_inc(sinc), .coin_count(cnt)
   );

   coin_collector #(.COIN_VALUE(9)) dut9 (
      .clk(clk), .reset_n(reset_n), .touch(touch), .x(x), .y(y),
      .frame_tick(frame_tick), .respawn(respawn),
      .map_wr_req(req9), .map_wr_x(wx9), .map_wr_y(wy9), .map_wr_tile(tile9),
      .map_wr_ack(map_wr_ack), .coin_visible(vis9), .pop_active(pact9),
      .pop_offset(off9), .score(score9), .score_inc(sinc9), .coin_count(cnt9)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        touch, ack, ft, resp;
      logic        req, vis, pact, sinc;
      logic [15:0] score;
      logic [7:0]  cnt;
      logic [2:0]  tile;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // One full collect/animate/respawn round trip, checking both score models.
   task automatic fast_collect(input int n);
      int e1, e9, ec;
      e1 = (n > 9999) ? 9999 : n;
      e9 = (n * 9 > 9999) ? 9999 : n * 9;
      ec = (n > 255) ? 255 : n;
      touch = 1'b1;
      step;
      chk("loop_sinc", 32'(sinc), 32'd1);
      chk("loop_sinc9", 32'(sinc9), 32'd1);
      chk("loop_score1", 32'(score), 32'(to_bcd(e1)));
      chk("loop_score9", 32'(score9), 32'(to_bcd(e9)));
      chk("loop_cnt", 32'(cnt), 32'(ec));
      touch = 1'b0;
      map_wr_ack = 1'b1;
      step;
      map_wr_ack = 1'b0;
      frame_tick = 1'b1;
      repeat (16) step;
      frame_tick = 1'b0;
      respawn = 1'b1;
      step;
      respawn = 1'b0;
      map_wr_ack = 1'b1;
      step;
      map_wr_ack = 1'b0;
      chk("loop_present", 32'(vis), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(req),   32'd0);
      chk({tag, "_vis"},   32'(vis),   32'd1);
      chk({tag, "_pact"},  32'(pact),  32'd0);
      chk({tag, "_off"},   32'(off),   32'd0);
      chk({tag, "_score"}, 32'(score), 32'd0);
      chk({tag, "_sinc"},  32'(sinc),  32'd0);
      chk({tag, "_cnt"},   32'(cnt),   32'd0);
      chk({tag, "_wx"},    32'(wx),    32'd0);
      chk({tag, "_wy"},    32'(wy),    32'd0);
      chk({tag, "_tile"},  32'(tile),  32'd1);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 8'd1, 3'd1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'd1, 3'd1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'd1, 3'd1};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'd1, 3'd1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'd1, 3'd1};

      reset_n = 1'b0; touch = 1'b0; frame_tick = 1'b0; respawn = 1'b0;
      map_wr_ack = 1'b0; x = 5; y = 7;
      step; step;
      chk_reset_vals("rst");
      reset_n = 1'b1;
      step;

      // Collection, then stay in the clear request with ack low
      for (int i = 0; i < 5; i++) begin
         touch = tbl[i].touch; map_wr_ack = tbl[i].ack;
         frame_tick = tbl[i].ft; respawn = tbl[i].resp;
         step;
         chk($sformatf("v%0d_req", i),   32'(req),   32'(tbl[i].req));
         chk($sformatf("v%0d_vis", i),   32'(vis),   32'(tbl[i].vis));
         chk($sformatf("v%0d_pact", i),  32'(pact),  32'(tbl[i].pact));
         chk($sformatf("v%0d_sinc", i),  32'(sinc),  32'(tbl[i].sinc));
         chk($sformatf("v%0d_score", i), 32'(score), 32'(tbl[i].score));
         chk($sformatf("v%0d_cnt", i),   32'(cnt),   32'(tbl[i].cnt));
         chk($sformatf("v%0d_tile", i),  32'(tile),  32'(tbl[i].tile));
         chk($sformatf("v%0d_wx", i),    32'(wx),    32'd5);
         chk($sformatf("v%0d_wy", i),    32'(wy),    32'd7);
         if (i == 0) begin x = 11; y = 12; end
      end
      frame_tick = 1'b0; respawn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step;
         chk("wait_req", 32'(req), 32'd1);
      end

      // Ack with a coincident frame_tick: the tick must not advance the pop
      map_wr_ack = 1'b1; frame_tick = 1'b1;
      step;
      map_wr_ack = 1'b0; frame_tick = 1'b0;
      chk("ack_req", 32'(req), 32'd0);
      chk("ack_pact", 32'(pact), 32'd1);
      chk("ack_off", 32'(off), 32'd0);

      // Sixteen frames of animation with respawn/touch noise in the gaps
      for (int k = 1; k <= 16; k++) begin
         frame_tick = 1'b1;
         step;
         frame_tick = 1'b0;
         chk($sformatf("pop%0d_off", k), 32'(off), (k < 16) ? 32'(2 * k) : 32'd0);
         chk($sformatf("pop%0d_pact", k), 32'(pact), (k < 16) ? 32'd1 : 32'd0);
         touch = (k == 2) ? 1'b0 : 1'b1;
         respawn = (k == 3);
         step;
         respawn = 1'b0;
         chk($sformatf("gap%0d_off", k), 32'(off), (k < 16) ? 32'(2 * k) : 32'd0);
         chk($sformatf("gap%0d_req", k), 32'(req), 32'd0);
         chk($sformatf("gap%0d_score", k), 32'(score), 32'h0001);
      end
      chk("coll_vis", 32'(vis), 32'd0);
      chk("coll_pact", 32'(pact), 32'd0);

      // Respawn with touch held high
      x = 9; y = 3; respawn = 1'b1;
      step;
      respawn = 1'b0;
      chk("rsp_req", 32'(req), 32'd1);
      chk("rsp_tile", 32'(tile), 32'd4);
      chk("rsp_wx", 32'(wx), 32'd9);
      chk("rsp_wy", 32'(wy), 32'd3);
      chk("rsp_vis", 32'(vis), 32'd0);
      map_wr_ack = 1'b1;
      step;
      map_wr_ack = 1'b0;
      chk("back_req", 32'(req), 32'd0);
      chk("back_vis", 32'(vis), 32'd1);
      step;
      chk("held_sinc", 32'(sinc), 32'd0);
      chk("held_score", 32'(score), 32'h0001);
      respawn = 1'b1;
      step;
      respawn = 1'b0;
      chk("pres_rsp_req", 32'(req), 32'd0);
      chk("pres_rsp_vis", 32'(vis), 32'd1);
      map_wr_ack = 1'b1;
      step;
      map_wr_ack = 1'b0;
      chk("stray_ack_vis", 32'(vis), 32'd1);
      touch = 1'b0;
      step;
      touch = 1'b1;
      step;
      chk("re_sinc", 32'(sinc), 32'd1);
      chk("re_score", 32'(score), 32'h0002);
      chk("re_score9", 32'(score9), 32'h0018);
      chk("re_cnt", 32'(cnt), 32'd2);
      chk("re_req", 32'(req), 32'd1);
      chk("re_tile", 32'(tile), 32'd1);

      // Reset while the clear request is outstanding
      reset_n = 1'b0; touch = 1'b0;
      step;
      chk_reset_vals("midrst");
      reset_n = 1'b1;
      step;

      // Long run: BCD carries, coin_count and score saturation
      for (int n = 1; n <= 1112; n++) fast_collect(n);
      chk("end_cnt9", 32'(cnt9), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/coin_collector.md
# coin_collector

Consumes the registered `touch` flag from the coin-tile touch detector and owns the lifecycle of one coin. On a new touch it removes the coin tile from the tile map through a request/acknowledge write port, adds points to a BCD score and plays a short upward "pop" animation. On a level `respawn` request it writes the coin back and re-arms. It sits between the touch detector and the tile-map/score/sprite logic, one instance per coin.

## Interface
- `TKN`, 4: tile code written to restore the coin.
- `SKY`, 1: tile code written to clear the coin.
- `COIN_VALUE`, 1: points added per collection, range 1–9.
- `POP_FRAMES`, 16: animation length, in `frame_tick` pulses.
- `POP_STEP`, 2: pixels of upward offset added per animation frame.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `touch`  in  1  registered touch flag from the detector; level signal.
- `x`  in  int  coin tile column, in block units.
- `y`  in  int  coin tile row, in block units.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `respawn`  in  1  one-cycle pulse requesting coin restore.
- `map_wr_req`  out  1  tile-map write request.
- `map_wr_x`  out  int  write column; equals `x` captured at request.
- `map_wr_y`  out  int  write row; equals `y` captured at request.
- `map_wr_tile`  out  3  tile code to write.
- `map_wr_ack`  in  1  tile-map write accepted.
- `coin_visible`  out  1  coin is drawn at rest.
- `pop_active`  out  1  pop animation is running.
- `pop_offset`  out  int  upward pixel offset of the pop sprite.
- `score`  out  16  four BCD digits; bits [15:12] are the thousands digit.
- `score_inc`  out  1  one-cycle pulse when a collection is accepted.
- `coin_count`  out  8  number of coins collected, saturating at 255.

## Operation
- Edge detect: `touch_d` registers `touch` every cycle in every state. A collection event is `touch && !touch_d`.
- FSM states are PRESENT, CLEAR_REQ, POP, COLLECTED and RESTORE_REQ.
  - PRESENT: `coin_visible`=1. A collection event moves to CLEAR_REQ and, on the same edge:
    - captures `x`/`y` into the write address;
    - sets `map_wr_tile`=SKY;
    - pulses `score_inc`;
    - adds COIN_VALUE to `score`;
    - increments `coin_count`.
  - CLEAR_REQ: `map_wr_req`=1 and `coin_visible`=0. When `map_wr_ack` is 1, go to POP and clear the pop counter and `pop_offset`.
  - POP: `pop_active`=1. Each `frame_tick` adds POP_STEP to `pop_offset` and increments the frame counter. When the counter reaches POP_FRAMES, go to COLLECTED and set `pop_offset` to 0.
  - COLLECTED: all indicators are 0. A `respawn` pulse sets `map_wr_tile`=TKN, captures `x`/`y`, and goes to RESTORE_REQ.
  - RESTORE_REQ: `map_wr_req`=1. When `map_wr_ack` is 1, go to PRESENT.
- Score arithmetic is BCD add with ripple carry across the digits.
  - The score saturates at 9999: an add that would exceed 9999 sets 9999.
  - `score_inc` and `coin_count` still update when the score is saturated.
- `coin_count` saturates at 255.
- `respawn` is ignored in every state except COLLECTED; it is not latched.
- Collection events are ignored in every state except PRESENT.
  - A touch held high across a respawn does not re-collect. A low-then-high transition on `touch` is required.
- `frame_tick` is ignored outside POP, including on the cycle `map_wr_ack` moves the FSM into POP.

## Timing
- Reset values:
  - state = PRESENT, `coin_visible`=1, `touch_d`=0;
  - `map_wr_req`=0, `map_wr_x`=0, `map_wr_y`=0, `map_wr_tile`=SKY;
  - `pop_active`=0, `pop_offset`=0, `score`=16'h0000, `score_inc`=0, `coin_count`=0.
- Reset mid-operation:
  - takes effect on the next edge;
  - drops `map_wr_req` with no ack needed;
  - abandons the animation;
  - leaves the coin present (the tile-map owner reloads the level on reset).
- Collection latency: `touch` rises at edge N, giving an event in cycle N. At edge N+1:
  - `score_inc`=1, `score`/`coin_count` show the new values;
  - `map_wr_req`=1, `coin_visible`=0.
- Handshake:
  - `map_wr_req`, `map_wr_x`, `map_wr_y` and `map_wr_tile` are registered outputs. They stay stable until ack.
  - Ack is sampled on every edge while `map_wr_req`=1, including the first request cycle.
  - `map_wr_req` falls on the edge after ack is sampled.
  - `map_wr_ack` is ignored while `map_wr_req`=0.
- POP:
  - starts the cycle after ack;
  - lasts exactly POP_FRAMES accepted `frame_tick` pulses;
  - `pop_offset` peaks at POP_FRAMES×POP_STEP − POP_STEP, then returns to 0 together with the COLLECTED transition.
- Respawn latency: `respawn` in COLLECTED gives `map_wr_req`=1 on the next edge, then PRESENT one cycle after ack.

## Test plan
- Reset, then `touch` 0→1 with x=5, y=7 → one cycle later: `score_inc`=1, `score`=0x0001, `coin_count`=1, `map_wr_req`=1, `map_wr_x`=5, `map_wr_y`=7, `map_wr_tile`=SKY, `coin_visible`=0.
- Hold ack low 10 cycles, then pulse it → `map_wr_req` stays high the whole wait and falls one cycle after ack. Then 16 `frame_tick`s → `pop_offset` steps 2,4,…,30, then 0 with `pop_active`=0.
- Hold `touch` high through COLLECTED, `respawn`, and ack → FSM returns to PRESENT with no second collection. Drop and re-raise `touch` → `score`=0x0002.
- Preload the score to 9999 via repeated collections with COIN_VALUE=9 → the next collection keeps `score`=0x9999 while `coin_count` increments. Also verify the carry from 0x0099 + 1 gives 0x0100.
- Pulse `respawn` and `touch` in POP and `respawn` in PRESENT → no state change, no write request.
- Assert `reset_n`=0 during CLEAR_REQ → next edge: `map_wr_req`=0, `coin_visible`=1, `score`=0, all outputs at their reset values.
